// File: rtl/mdio_responder.sv
// mdio_responder: Clause-22 MDIO management slave (PHY side).
// Oversamples MDC on the system clock, decodes read/write frames addressed to
// PHY_ADDR, strobes a simple register port and drives read data back on MDIO.
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   mdc, mdio_in         asynchronous management clock / data pad input
//   mdio_out, mdio_oen   pad drive value and enable (oen=1 releases the pad)
//   reg_addr             REGAD of the current frame
//   reg_rd, reg_rdata    one-cycle read strobe; data valid from the next cycle
//   reg_wr, reg_wdata    one-cycle write strobe with write data
//   busy                 high from ST detection until the frame ends
//   frame_err            one-cycle pulse on an illegal opcode
//
// Build option: define MDIO_RESP_PREAMBLE_SUPPRESS_EN to accept a single
// preamble 1 before ST instead of PREAMBLE_MIN ones.
module mdio_responder #(
  parameter logic [4:0]  PHY_ADDR     = 5'd1,
  parameter int unsigned PREAMBLE_MIN = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdc,
  input  logic        mdio_in,
  output logic        mdio_out,
  output logic        mdio_oen,
  output logic [4:0]  reg_addr,
  output logic        reg_rd,
  input  logic [15:0] reg_rdata,
  output logic        reg_wr,
  output logic [15:0] reg_wdata,
  output logic        busy,
  output logic        frame_err
);

`ifdef MDIO_RESP_PREAMBLE_SUPPRESS_EN
  localparam logic [5:0] EffMin = 6'd1;
`else
  localparam logic [5:0] EffMin = 6'(PREAMBLE_MIN);
`endif

  typedef enum logic [2:0] {StPre, StSt, StOp, StAddr, StTa, StData} state_e;

  logic       mdc_s1, mdc_s2, mdc_s3, mdio_s1, mdio_s2;
  logic       mdc_rise, mdc_fall;

  state_e     state_q, state_d;
  logic [5:0] pre_cnt_q, pre_cnt_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic       is_read_q, is_read_d;
  logic       match_q, match_d;
  logic [15:0] sr_q, sr_d;
  logic [4:0] reg_addr_q, reg_addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic       rd_q, rd_d, wr_q, wr_d, err_q, err_d;
  logic       out_q, out_d, oen_q, oen_d;
  logic       rd_match;

  assign mdc_rise = mdc_s2 & ~mdc_s3;
  assign mdc_fall = ~mdc_s2 & mdc_s3;
  assign rd_match = is_read_q & match_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mdc_s1     <= 1'b0;
      mdc_s2     <= 1'b0;
      mdc_s3     <= 1'b0;
      mdio_s1    <= 1'b0;
      mdio_s2    <= 1'b0;
      state_q    <= StPre;
      pre_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      is_read_q  <= 1'b0;
      match_q    <= 1'b0;
      sr_q       <= '0;
      reg_addr_q <= '0;
      wdata_q    <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      out_q      <= 1'b0;
      oen_q      <= 1'b1;
    end else begin
      mdc_s1     <= mdc;
      mdc_s2     <= mdc_s1;
      mdc_s3     <= mdc_s2;
      mdio_s1    <= mdio_in;
      mdio_s2    <= mdio_s1;
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      is_read_q  <= is_read_d;
      match_q    <= match_d;
      sr_q       <= sr_d;
      reg_addr_q <= reg_addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      err_q      <= err_d;
      out_q      <= out_d;
      oen_q      <= oen_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    is_read_d  = is_read_q;
    match_d    = match_q;
    sr_d       = sr_q;
    reg_addr_d = reg_addr_q;
    wdata_d    = wdata_q;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    err_d      = 1'b0;
    out_d      = out_q;
    oen_d      = oen_q;

    if (mdc_rise) begin
      unique case (state_q)
        StPre: begin
          if (mdio_s2) begin
            pre_cnt_d = (pre_cnt_q == 6'd63) ? 6'd63 : pre_cnt_q + 6'd1;
          end else begin
            // This 0 is the first ST bit when enough preamble preceded it.
            if (pre_cnt_q >= EffMin) state_d = StSt;
            pre_cnt_d = '0;
          end
        end
        StSt: begin
          bit_cnt_d = '0;
          state_d   = mdio_s2 ? StOp : StPre;
        end
        StOp: begin
          sr_d = {sr_q[14:0], mdio_s2};
          if (bit_cnt_q == 4'd1) begin
            bit_cnt_d = '0;
            unique case ({sr_q[0], mdio_s2})
              2'b10: begin is_read_d = 1'b1; state_d = StAddr; end
              2'b01: begin is_read_d = 1'b0; state_d = StAddr; end
              default: begin
                err_d     = 1'b1;
                state_d   = StPre;
                pre_cnt_d = '0;
              end
            endcase
          end else begin
            bit_cnt_d = 4'd1;
          end
        end
        StAddr: begin
          sr_d = {sr_q[14:0], mdio_s2};
          if (bit_cnt_q == 4'd9) begin
            // sr_q[8:4] = PHYAD, {sr_q[3:0], current bit} = REGAD
            match_d    = (sr_q[8:4] == PHY_ADDR);
            reg_addr_d = {sr_q[3:0], mdio_s2};
            rd_d       = is_read_q & (sr_q[8:4] == PHY_ADDR);
            bit_cnt_d  = '0;
            state_d    = StTa;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        StTa: begin
          if (bit_cnt_q == 4'd0) begin
            if (rd_match) sr_d = reg_rdata;
            bit_cnt_d = 4'd1;
          end else begin
            bit_cnt_d = '0;
            state_d   = StData;
          end
        end
        StData: begin
          if (!is_read_q) sr_d = {sr_q[14:0], mdio_s2};
          if (bit_cnt_q == 4'd15) begin
            if (!is_read_q && match_q) begin
              wr_d    = 1'b1;
              wdata_d = {sr_q[14:0], mdio_s2};
            end
            bit_cnt_d = '0;
            pre_cnt_d = '0;
            state_d   = StPre;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        default: state_d = StPre;
      endcase
    end

    // Pad updates happen only on MDC falling edges; the fall after D0 lands
    // in StPre and therefore releases the pad.
    if (mdc_fall) begin
      if (state_q == StTa && bit_cnt_q == 4'd1 && rd_match) begin
        oen_d = 1'b0;
        out_d = 1'b0;
      end else if (state_q == StData && rd_match) begin
        oen_d = 1'b0;
        out_d = sr_q[15];
        sr_d  = {sr_q[14:0], 1'b0};
      end else begin
        oen_d = 1'b1;
        out_d = 1'b0;
      end
    end
  end

  assign mdio_out  = out_q;
  assign mdio_oen  = oen_q;
  assign reg_addr  = reg_addr_q;
  assign reg_rd    = rd_q;
  assign reg_wr    = wr_q;
  assign reg_wdata = wdata_q;
  assign frame_err = err_q;
  assign busy      = (state_q != StPre);

endmodule

// File: tb/tb_mdio_responder.sv
// Bench for mdio_responder: an MDIO master model drives frames from a vector
// table; a scoreboard checks register strobes as the DUT produces them.
module tb_mdio_responder;

  localparam int H = 8;             // MDC half period in clk cycles
  localparam logic [4:0] PHY = 5'd1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mdc = 1'b0;
  logic        m_drv = 1'b1;
  logic        mdio_in, mdio_out, mdio_oen;
  logic [4:0]  reg_addr;
  logic        reg_rd, reg_wr, busy, frame_err;
  logic [15:0] reg_rdata = '0;
  logic [15:0] reg_wdata;
  logic [15:0] rd_val = '0;

  int tests = 0, fails = 0;
  int wr_cnt = 0, rd_cnt = 0, err_cnt = 0, oen_bad = 0;
  logic drive_ok = 1'b0;
  logic [20:0] exp_wr_q[$];
  logic [4:0]  exp_rd_q[$];

  // Open-drain wire with pull-up: master and DUT both pull low.
  assign mdio_in = m_drv & (mdio_oen | mdio_out);

  always #4 clk = ~clk;

  mdio_responder #(.PHY_ADDR(5'd1), .PREAMBLE_MIN(32)) dut (
    .clk(clk), .reset(reset), .mdc(mdc), .mdio_in(mdio_in),
    .mdio_out(mdio_out), .mdio_oen(mdio_oen), .reg_addr(reg_addr),
    .reg_rd(reg_rd), .reg_rdata(reg_rdata), .reg_wr(reg_wr),
    .reg_wdata(reg_wdata), .busy(busy), .frame_err(frame_err)
  );

  // Register model: read data becomes valid the cycle after reg_rd.
  always @(posedge clk) if (reg_rd) reg_rdata <= rd_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard / monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (reg_wr) begin
        wr_cnt++;
        if (exp_wr_q.size() == 0) check("unexpected reg_wr", 1, 0);
        else begin
          logic [20:0] e;
          e = exp_wr_q.pop_front();
          check("reg_wr addr/data", {11'd0, reg_addr, reg_wdata}, {11'd0, e});
        end
      end
      if (reg_rd) begin
        rd_cnt++;
        if (exp_rd_q.size() == 0) check("unexpected reg_rd", 1, 0);
        else begin
          logic [4:0] a;
          a = exp_rd_q.pop_front();
          check("reg_rd addr", {27'd0, reg_addr}, {27'd0, a});
        end
      end
      if (frame_err) err_cnt++;
      if (!mdio_oen && !drive_ok) oen_bad++;
    end
  end

  task automatic mdc_bit(input logic b, output logic s);
    @(negedge clk) m_drv = b;
    repeat (H) @(negedge clk);
    s = mdio_in;
    mdc = 1'b1;
    repeat (H) @(negedge clk);
    mdc = 1'b0;
  endtask

  task automatic do_frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                          input logic [4:0] ra, input logic [15:0] data, input int abort_at,
                          output logic [15:0] rd, output logic ta2);
    logic s;
    logic [13:0] hdr;
    logic aborted;
    hdr = {2'b01, op, phy, ra};
    rd = '0;
    ta2 = 1'b1;
    aborted = 1'b0;
    for (int i = 0; i < pre; i++) mdc_bit(1'b1, s);
    for (int i = 13; i >= 0; i--) mdc_bit(hdr[i], s);
    if (op == 2'b10) begin
      drive_ok = (phy == PHY);
      mdc_bit(1'b1, s);
      mdc_bit(1'b1, ta2);
      for (int i = 15; i >= 0; i--) begin
        if (!aborted) begin
          if (i == abort_at) begin
            @(negedge clk) m_drv = 1'b1;
            repeat (H) @(negedge clk);
            check("oen driving before reset", {31'd0, mdio_oen}, 32'd0);
            reset = 1'b1;
            @(negedge clk);
            check("oen after mid-frame reset", {31'd0, mdio_oen}, 32'd1);
            reset = 1'b0;
            repeat (H) @(negedge clk);
            check("busy after mid-frame reset", {31'd0, busy}, 32'd0);
            aborted = 1'b1;
          end else begin
            mdc_bit(1'b1, s);
            rd[i] = s;
          end
        end
      end
    end else begin
      mdc_bit(1'b1, s);
      mdc_bit(1'b0, s);
      for (int i = 15; i >= 0; i--) mdc_bit(data[i], s);
    end
    m_drv = 1'b1;
    repeat (H) @(negedge clk);
    drive_ok = 1'b0;
  endtask

  typedef struct {
    int          pre;
    logic [1:0]  op;
    logic [4:0]  phy;
    logic [4:0]  ra;
    logic [15:0] data;
    logic        acc;
    logic        err;
  } vec_t;

`ifdef MDIO_RESP_PREAMBLE_SUPPRESS_EN
  localparam logic ShortOk = 1'b1;
`else
  localparam logic ShortOk = 1'b0;
`endif

  initial begin
    vec_t vecs[8];
    logic [15:0] rd;
    logic ta2;
    int w0, r0, e0;

    vecs[0] = '{32, 2'b01, 5'd1, 5'h04, 16'hA5C3, 1'b1, 1'b0};
    vecs[1] = '{32, 2'b10, 5'd1, 5'h02, 16'h0141, 1'b1, 1'b0};
    vecs[2] = '{32, 2'b10, 5'd3, 5'h02, 16'h1234, 1'b0, 1'b0};
    vecs[3] = '{32, 2'b01, 5'd1, 5'h07, 16'h5AA5, 1'b1, 1'b0};
    vecs[4] = '{31, 2'b01, 5'd1, 5'h09, 16'h3C3C, ShortOk, 1'b0};
    vecs[5] = '{32, 2'b11, 5'd1, 5'h00, 16'h0000, 1'b0, 1'b1};
    vecs[6] = '{32, 2'b10, 5'd1, 5'h1F, 16'h8001, 1'b1, 1'b0};
    vecs[7] = '{32, 2'b01, 5'd1, 5'h1F, 16'hFFFF, 1'b1, 1'b0};

    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset oen", {31'd0, mdio_oen}, 32'd1);
    check("reset out", {31'd0, mdio_out}, 32'd0);
    check("reset strobes", {29'd0, reg_rd, reg_wr, frame_err}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset reg_addr", {27'd0, reg_addr}, 32'd0);
    check("reset reg_wdata", {16'd0, reg_wdata}, 32'd0);

    for (int k = 0; k < 8; k++) begin
      rd_val = vecs[k].data;
      if (vecs[k].acc && vecs[k].op == 2'b01) exp_wr_q.push_back({vecs[k].ra, vecs[k].data});
      if (vecs[k].acc && vecs[k].op == 2'b10) exp_rd_q.push_back(vecs[k].ra);
      w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
      do_frame(vecs[k].pre, vecs[k].op, vecs[k].phy, vecs[k].ra, vecs[k].data, -1, rd, ta2);
      check($sformatf("v%0d reg_wr count", k), wr_cnt - w0,
            (vecs[k].acc && vecs[k].op == 2'b01) ? 1 : 0);
      check($sformatf("v%0d reg_rd count", k), rd_cnt - r0,
            (vecs[k].acc && vecs[k].op == 2'b10) ? 1 : 0);
      check($sformatf("v%0d frame_err count", k), err_cnt - e0, vecs[k].err ? 1 : 0);
      if (vecs[k].acc && vecs[k].op == 2'b10) begin
        check($sformatf("v%0d TA2 bit", k), {31'd0, ta2}, 32'd0);
        check($sformatf("v%0d read data", k), {16'd0, rd}, {16'd0, vecs[k].data});
      end
      check($sformatf("v%0d oen after frame", k), {31'd0, mdio_oen}, 32'd1);
      check($sformatf("v%0d busy after frame", k), {31'd0, busy}, 32'd0);
      check($sformatf("v%0d unexpected drive", k), oen_bad, 0);
    end

    // Reset during read data bit 7, then a clean read.
    rd_val = 16'hBEEF;
    exp_rd_q.push_back(5'h02);
    w0 = wr_cnt; r0 = rd_cnt;
    do_frame(32, 2'b10, 5'd1, 5'h02, 16'h0000, 7, rd, ta2);
    check("abort reg_wr count", wr_cnt - w0, 0);
    check("abort reg_rd count", rd_cnt - r0, 1);
    check("abort read prefix", {24'd0, rd[15:8]}, 32'h00BE);
    rd_val = 16'h0141;
    exp_rd_q.push_back(5'h02);
    do_frame(32, 2'b10, 5'd1, 5'h02, 16'h0000, -1, rd, ta2);
    check("post-reset TA2", {31'd0, ta2}, 32'd0);
    check("post-reset read data", {16'd0, rd}, 32'h0000_0141);
    check("post-reset reg_rd count", rd_cnt - r0, 2);
    check("scoreboard drained", exp_wr_q.size() + exp_rd_q.size(), 0);
    check("no unexpected drive", oen_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
